// File: rtl/gvt_epoch_ctrl_pkg.sv
// rtl/gvt_epoch_ctrl_pkg.sv - shared types for the GVT epoch controller
package gvt_epoch_ctrl_pkg;

    localparam int TS_WIDTH = 16;
    localparam int TB_WIDTH = 8;
    localparam int N_TILES  = 16;

    // ts sits above tb, so a plain unsigned compare orders by ts, then tb
    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [TB_WIDTH-1:0] tb;
    } vt_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        REDUCE,
        PUBLISH
    } gvt_epoch_state_t;

    function automatic vt_t vt_min(input vt_t a, input vt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/gvt_epoch_ctrl_if.sv
// rtl/gvt_epoch_ctrl_if.sv - tile LVT handshake and GVT publication bundle
interface gvt_epoch_ctrl_if #(
    parameter int N = 16
);
    import gvt_epoch_ctrl_pkg::*;

    logic         en;
    logic [N-1:0] snap_req;
    logic [N-1:0] lvt_valid;
    vt_t  [N-1:0] lvt;
    logic [N-1:0] lvt_ready;
    vt_t          gvt;
    logic         gvt_valid;
    logic         gvt_regress;
    logic         timeout;
    logic         epoch_busy;

    modport master (
        input  en, lvt_valid, lvt,
        output snap_req, lvt_ready, gvt, gvt_valid, gvt_regress, timeout, epoch_busy
    );

    modport slave (
        output en, lvt_valid, lvt,
        input  snap_req, lvt_ready, gvt, gvt_valid, gvt_regress, timeout, epoch_busy
    );

endinterface

// File: rtl/gvt_seq_min.sv
// rtl/gvt_seq_min.sv - sequential minimum over the slot array with one comparator
module gvt_seq_min
    import gvt_epoch_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  vt_t                  din,
    output logic [$clog2(N)-1:0] idx,
    output vt_t                  acc_next,
    output logic                 done
);
    localparam int IDX_W = $clog2(N);

    vt_t acc;

    // acc_next is the running minimum including the slot currently addressed by idx
    assign acc_next = vt_min(acc, din);
    assign done     = step && (idx == IDX_W'(N - 1));

    // accumulator and slot index: start rearms, each step folds in one slot
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '1;
            idx <= '0;
        end else if (start) begin
            acc <= '1;
            idx <= '0;
        end else if (step) begin
            acc <= acc_next;
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/gvt_epoch_ctrl.sv
// rtl/gvt_epoch_ctrl.sv - epoch sequencer that snapshots tile LVTs and publishes GVT
module gvt_epoch_ctrl #(
    parameter int N_TILES        = gvt_epoch_ctrl_pkg::N_TILES,
    parameter int EPOCH_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic              clk,
    input logic              rst,
    gvt_epoch_ctrl_if.master bus
);
    import gvt_epoch_ctrl_pkg::*;

    localparam int CNT_W = $clog2(EPOCH_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = $clog2(N_TILES);

    gvt_epoch_state_t   state;
    gvt_epoch_state_t   state_next;
    logic [CNT_W-1:0]   epoch_cnt;
    logic [TMR_W-1:0]   timer;
    logic [N_TILES-1:0] snap_req;
    logic [N_TILES-1:0] accept;
    logic [N_TILES-1:0] pending_next;
    vt_t                slot [N_TILES];
    vt_t                gvt;
    logic               gvt_valid;
    logic               gvt_regress;
    logic               timeout;
    logic               epoch_start;
    logic               collect_done;
    logic               collect_abort;
    logic               reduce_done;
    logic [IDX_W-1:0]   reduce_idx;
    vt_t                reduce_min;

    // snap_req doubles as the pending mask: a tile is outstanding exactly while its request is up
    assign accept       = (state == COLLECT) ? (bus.lvt_valid & snap_req) : '0;
    assign pending_next = snap_req & ~accept;

    // next state and epoch control strobes
    always_comb begin
        state_next    = state;
        epoch_start   = 1'b0;
        collect_done  = 1'b0;
        collect_abort = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && (epoch_cnt == CNT_W'(EPOCH_CYCLES - 1))) begin
                    epoch_start = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: state_next = COLLECT;
            COLLECT: begin
                // completion is checked first so a final accept in the last timer cycle still publishes
                if (pending_next == '0) begin
                    collect_done = 1'b1;
                    state_next   = REDUCE;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    collect_abort = 1'b1;
                    state_next    = IDLE;
                end
            end
            REDUCE:  if (reduce_done) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // idle spacing counter (held while en is low) and collect timer
    always_ff @(posedge clk) begin
        if (rst) begin
            epoch_cnt <= '0;
            timer     <= '0;
        end else begin
            if ((state != IDLE) || epoch_start) epoch_cnt <= '0;
            else if (bus.en)                    epoch_cnt <= epoch_cnt + CNT_W'(1);
            if (state == REQ)                   timer <= '0;
            else if (state == COLLECT)          timer <= timer + TMR_W'(1);
        end
    end

    // per-tile request/accept handshake and snapshot slots
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_req <= '0;
            for (int i = 0; i < N_TILES; i++) slot[i] <= '0;
        end else begin
            if (state == REQ)          snap_req <= '1;
            else if (state == COLLECT) snap_req <= collect_abort ? '0 : pending_next;
            for (int i = 0; i < N_TILES; i++) begin
                if (accept[i]) slot[i] <= bus.lvt[i];
            end
        end
    end

    gvt_seq_min #(.N(N_TILES)) u_seq_min (
        .clk      (clk),
        .rst      (rst),
        .start    (collect_done),
        .step     (state == REDUCE),
        .din      (slot[reduce_idx]),
        .idx      (reduce_idx),
        .acc_next (reduce_min),
        .done     (reduce_done)
    );

    // the last reduction step registers the result so it is visible during PUBLISH; gvt never moves back
    always_ff @(posedge clk) begin
        if (rst) begin
            gvt         <= '0;
            gvt_valid   <= 1'b0;
            gvt_regress <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            gvt_valid   <= 1'b0;
            gvt_regress <= 1'b0;
            timeout     <= collect_abort;
            if (reduce_done) begin
                if (reduce_min >= gvt) begin
                    gvt       <= reduce_min;
                    gvt_valid <= 1'b1;
                end else begin
                    gvt_regress <= 1'b1;
                end
            end
        end
    end

    assign bus.snap_req    = snap_req;
    assign bus.lvt_ready   = snap_req;
    assign bus.gvt         = gvt;
    assign bus.gvt_valid   = gvt_valid;
    assign bus.gvt_regress = gvt_regress;
    assign bus.timeout     = timeout;
    assign bus.epoch_busy  = (state != IDLE);

endmodule

// File: tb/tb_gvt_epoch_ctrl.sv
// tb/tb_gvt_epoch_ctrl.sv - directed self-checking bench for gvt_epoch_ctrl
module tb_gvt_epoch_ctrl;
    import gvt_epoch_ctrl_pkg::*;

    localparam int NT   = 4;
    localparam int EP   = 8;
    localparam int TO   = 32;
    localparam int HIST = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gvt_epoch_ctrl_if #(.N(NT)) bus();

    gvt_epoch_ctrl #(
        .N_TILES        (NT),
        .EPOCH_CYCLES   (EP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           resp_dly [NT];
    vt_t          resp_val [NT];
    int           age [NT];
    logic [NT-1:0] sr_hist [HIST];
    int           ev_off;
    logic         ev_gv, ev_rg, ev_to;
    logic [NT-1:0] ev_sr;
    vt_t          ev_gvt;

    int           st_off [6] = '{1, 2, 6, 7, 10, 11};
    logic [NT-1:0] st_sr  [6] = '{4'hF, 4'hA, 4'hA, 4'h8, 4'h8, 4'h0};

    function automatic vt_t mk_vt(input int ts, input int tb);
        vt_t v;
        v.ts = TS_WIDTH'(ts);
        v.tb = TB_WIDTH'(tb);
        return v;
    endfunction

    // tile model: tile i raises valid resp_dly[i] cycles after its request appears, holds until accepted
    initial begin
        bus.lvt_valid = '0;
        bus.lvt       = '0;
        for (int i = 0; i < NT; i++) age[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NT; i++) begin
                if (bus.snap_req[i]) begin
                    if (resp_dly[i] >= 0 && age[i] >= resp_dly[i]) begin
                        bus.lvt_valid[i] = 1'b1;
                        bus.lvt[i]       = resp_val[i];
                    end
                    age[i]++;
                end else begin
                    bus.lvt_valid[i] = 1'b0;
                    age[i]           = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input int i, input int d, input int ts, input int tb);
        resp_dly[i] = d;
        resp_val[i] = mk_vt(ts, tb);
    endtask

    task automatic wait_snap(output int n);
        n = 0;
        while (bus.snap_req == '0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // offset 0 is the first cycle snap_req is visible; stops at the first pulse
    task automatic record_epoch(input int en_off);
        ev_off = -1;
        ev_gv  = 1'b0;
        ev_rg  = 1'b0;
        ev_to  = 1'b0;
        ev_sr  = '0;
        ev_gvt = '0;
        for (int k = 0; k < HIST; k++) begin
            sr_hist[k] = bus.snap_req;
            if (k == en_off) bus.en = 1'b0;
            if (bus.gvt_valid || bus.gvt_regress || bus.timeout) begin
                ev_off = k;
                ev_gv  = bus.gvt_valid;
                ev_rg  = bus.gvt_regress;
                ev_to  = bus.timeout;
                ev_sr  = bus.snap_req;
                ev_gvt = bus.gvt;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        bus.en = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.gvt !== mk_vt(0, 0)) begin errors++; $display("FAIL reset_gvt got %0d.%0d want 0.0", bus.gvt.ts, bus.gvt.tb); end
        checks++;
        if (bus.snap_req !== '0 || bus.lvt_ready !== '0) begin errors++; $display("FAIL reset_snap_req got %b/%b want 0", bus.snap_req, bus.lvt_ready); end
        checks++;
        if ({bus.gvt_valid, bus.gvt_regress, bus.timeout, bus.epoch_busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {bus.gvt_valid, bus.gvt_regress, bus.timeout, bus.epoch_busy});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        set_tile(0, 1, 50, 0); set_tile(1, 1, 20, 0); set_tile(2, 1, 70, 0); set_tile(3, 1, 30, 0);
        wait_snap(n);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL basic_first_req got %0d want 9", n); end
        record_epoch(-1);
        checks++;
        if (sr_hist[1] !== 4'hF || sr_hist[2] !== 4'h0) begin errors++; $display("FAIL basic_snap_drop got %h,%h want f,0", sr_hist[1], sr_hist[2]); end
        checks++;
        if (ev_off !== 6 || ev_gv !== 1'b1) begin errors++; $display("FAIL basic_latency got off=%0d gv=%b want 6,1", ev_off, ev_gv); end
        checks++;
        if (ev_gvt !== mk_vt(20, 0)) begin errors++; $display("FAIL basic_gvt got %0d.%0d want 20.0", ev_gvt.ts, ev_gvt.tb); end
    endtask

    task automatic test_tiebreak();
        int n;
        set_tile(0, 1, 20, 5); set_tile(1, 1, 20, 2); set_tile(2, 1, 60, 0); set_tile(3, 1, 25, 0);
        wait_snap(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL tiebreak_period got %0d want 10", n); end
        record_epoch(-1);
        checks++;
        if (ev_off !== 6 || ev_gv !== 1'b1 || ev_gvt !== mk_vt(20, 2)) begin
            errors++; $display("FAIL tiebreak_gvt got off=%0d gv=%b %0d.%0d want 6,1 20.2", ev_off, ev_gv, ev_gvt.ts, ev_gvt.tb);
        end
    endtask

    task automatic test_staggered();
        int n;
        set_tile(0, 1, 33, 1); set_tile(1, 6, 25, 7); set_tile(2, 1, 47, 3); set_tile(3, 10, 60, 9);
        wait_snap(n);
        record_epoch(-1);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (sr_hist[st_off[j]] !== st_sr[j]) begin
                errors++; $display("FAIL stagger_snap_req[%0d] got %h want %h", st_off[j], sr_hist[st_off[j]], st_sr[j]);
            end
        end
        checks++;
        if (ev_off !== 15 || ev_gv !== 1'b1) begin errors++; $display("FAIL stagger_latency got off=%0d gv=%b want 15,1", ev_off, ev_gv); end
        checks++;
        if (ev_gvt !== mk_vt(25, 7)) begin errors++; $display("FAIL stagger_gvt got %0d.%0d want 25.7", ev_gvt.ts, ev_gvt.tb); end
    endtask

    task automatic test_regression();
        int n;
        set_tile(0, 1, 40, 0); set_tile(1, 1, 41, 0); set_tile(2, 1, 55, 0); set_tile(3, 1, 60, 0);
        wait_snap(n);
        record_epoch(-1);
        checks++;
        if (ev_gv !== 1'b1 || ev_gvt !== mk_vt(40, 0)) begin errors++; $display("FAIL regress_setup got gv=%b %0d.%0d want 1 40.0", ev_gv, ev_gvt.ts, ev_gvt.tb); end
        set_tile(0, 1, 35, 0); set_tile(1, 1, 50, 0); set_tile(2, 1, 45, 0); set_tile(3, 1, 38, 0);
        wait_snap(n);
        record_epoch(-1);
        checks++;
        if (ev_off !== 6 || ev_rg !== 1'b1 || ev_gv !== 1'b0) begin
            errors++; $display("FAIL regress_pulse got off=%0d rg=%b gv=%b want 6,1,0", ev_off, ev_rg, ev_gv);
        end
        tick();
        checks++;
        if (bus.gvt !== mk_vt(40, 0)) begin errors++; $display("FAIL regress_hold got %0d.%0d want 40.0", bus.gvt.ts, bus.gvt.tb); end
        set_tile(0, 1, 44, 0); set_tile(1, 1, 40, 0); set_tile(2, 1, 48, 0); set_tile(3, 1, 52, 0);
        wait_snap(n);
        record_epoch(-1);
        checks++;
        if (ev_gv !== 1'b1 || ev_rg !== 1'b0 || ev_gvt !== mk_vt(40, 0)) begin
            errors++; $display("FAIL equal_min got gv=%b rg=%b %0d.%0d want 1,0 40.0", ev_gv, ev_rg, ev_gvt.ts, ev_gvt.tb);
        end
    endtask

    task automatic test_timeout();
        int n;
        set_tile(0, 1, 10, 0); set_tile(1, 1, 11, 0); set_tile(2, 1, 12, 0); set_tile(3, -1, 13, 0);
        wait_snap(n);
        record_epoch(-1);
        checks++;
        if (ev_off !== 32 || ev_to !== 1'b1 || ev_gv !== 1'b0 || ev_rg !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got off=%0d to=%b gv=%b rg=%b want 32,1,0,0", ev_off, ev_to, ev_gv, ev_rg);
        end
        checks++;
        if (sr_hist[31] !== 4'h8 || ev_sr !== 4'h0) begin errors++; $display("FAIL timeout_snap_req got %h,%h want 8,0", sr_hist[31], ev_sr); end
        checks++;
        if (ev_gvt !== mk_vt(40, 0)) begin errors++; $display("FAIL timeout_gvt got %0d.%0d want 40.0", ev_gvt.ts, ev_gvt.tb); end
        set_tile(0, 1, 50, 0); set_tile(1, 1, 45, 0); set_tile(2, 1, 60, 0); set_tile(3, 31, 42, 3);
        wait_snap(n);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL timeout_restart got %0d want 9", n); end
        record_epoch(-1);
        checks++;
        if (ev_off !== 36 || ev_gv !== 1'b1 || ev_to !== 1'b0) begin
            errors++; $display("FAIL edge_accept got off=%0d gv=%b to=%b want 36,1,0", ev_off, ev_gv, ev_to);
        end
        checks++;
        if (ev_gvt !== mk_vt(42, 3)) begin errors++; $display("FAIL edge_accept_gvt got %0d.%0d want 42.3", ev_gvt.ts, ev_gvt.tb); end
    endtask

    task automatic test_enable();
        int n;
        int busy_cnt;
        set_tile(0, 1, 50, 0); set_tile(1, 2, 44, 0); set_tile(2, 5, 47, 0); set_tile(3, 4, 61, 0);
        wait_snap(n);
        record_epoch(3);
        checks++;
        if (ev_off !== 10 || ev_gv !== 1'b1 || ev_gvt !== mk_vt(44, 0)) begin
            errors++; $display("FAIL en_drop_epoch got off=%0d gv=%b %0d.%0d want 10,1 44.0", ev_off, ev_gv, ev_gvt.ts, ev_gvt.tb);
        end
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.snap_req != '0 || bus.epoch_busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0) begin errors++; $display("FAIL en_low_quiet got %0d busy cycles want 0", busy_cnt); end
        set_tile(0, 1, 46, 0); set_tile(1, 1, 49, 0); set_tile(2, 1, 58, 0); set_tile(3, 1, 47, 1);
        bus.en = 1'b1;
        wait_snap(n);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL en_restart got %0d want 9", n); end
        record_epoch(-1);
        checks++;
        if (ev_gv !== 1'b1 || ev_gvt !== mk_vt(46, 0)) begin errors++; $display("FAIL en_restart_gvt got gv=%b %0d.%0d want 1 46.0", ev_gv, ev_gvt.ts, ev_gvt.tb); end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulse_cnt;
        set_tile(0, 1, 70, 0); set_tile(1, 1, 71, 0); set_tile(2, 1, 72, 0); set_tile(3, 1, 73, 0);
        wait_snap(n);
        repeat (3) tick();
        checks++;
        if (bus.epoch_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", bus.epoch_busy); end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.gvt !== mk_vt(0, 0) || bus.snap_req !== '0) begin
            errors++; $display("FAIL midrst_state got gvt=%0d.%0d snap=%h want 0.0,0", bus.gvt.ts, bus.gvt.tb, bus.snap_req);
        end
        checks++;
        if ({bus.gvt_valid, bus.gvt_regress, bus.timeout, bus.epoch_busy} !== 4'b0000) begin
            errors++; $display("FAIL midrst_flags got %b want 0000", {bus.gvt_valid, bus.gvt_regress, bus.timeout, bus.epoch_busy});
        end
        rst = 1'b0;
        pulse_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.gvt_valid || bus.gvt_regress || bus.timeout) pulse_cnt++;
        end
        checks++;
        if (pulse_cnt !== 0) begin errors++; $display("FAIL midrst_no_publish got %0d pulses want 0", pulse_cnt); end
        set_tile(0, 1, 5, 0); set_tile(1, 1, 9, 0); set_tile(2, 1, 6, 0); set_tile(3, 1, 7, 0);
        wait_snap(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL midrst_restart got %0d want 3", n); end
        record_epoch(-1);
        checks++;
        if (ev_gv !== 1'b1 || ev_gvt !== mk_vt(5, 0)) begin errors++; $display("FAIL midrst_gvt got gv=%b %0d.%0d want 1 5.0", ev_gv, ev_gvt.ts, ev_gvt.tb); end
    endtask

    initial begin
        bus.en = 1'b0;
        for (int i = 0; i < NT; i++) set_tile(i, -1, 0, 0);
        test_reset();
        test_basic();
        test_tiebreak();
        test_staggered();
        test_regression();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
